// File: rtl/intra_net_sched_if.sv
// Job-descriptor handshake bundle for intra_net_sched.
interface intra_net_sched_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int COL_DIM    = 16,
    parameter int TILE_W     = 8
);
    logic                        cfg_valid;
    logic                        cfg_ready;
    logic [ADDR_WIDTH-1:0]       cfg_o_base;
    logic [ADDR_WIDTH-1:0]       cfg_a_base;
    logic [ADDR_WIDTH-1:0]       cfg_o_stride;
    logic [ADDR_WIDTH-1:0]       cfg_a_stride;
    logic [ADDR_WIDTH-1:0]       cfg_rows;
    logic [TILE_W-1:0]           cfg_tiles;
    logic [$clog2(COL_DIM)-1:0]  cfg_delay;

    modport master (
        output cfg_valid, cfg_o_base, cfg_a_base, cfg_o_stride, cfg_a_stride,
               cfg_rows, cfg_tiles, cfg_delay,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_o_base, cfg_a_base, cfg_o_stride, cfg_a_stride,
               cfg_rows, cfg_tiles, cfg_delay,
        output cfg_ready
    );
endinterface

// File: rtl/intra_net_sched.sv
// Tile sequencer for the output-to-activation copy path; drives the address generator.
// Define INTRA_NET_SCHED_PERF_EN to add the perf_cycles start-high cycle counter.
module intra_net_sched #(
    parameter int ADDR_WIDTH = 10,
    parameter int COL_DIM    = 16,
    parameter int TILE_W     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    intra_net_sched_if.slave            cfg,
    input  logic                        abort,
    output logic                        start_signal,
    output logic [ADDR_WIDTH-1:0]       O_base_addr,
    output logic [ADDR_WIDTH-1:0]       A_base_addr,
    output logic [$clog2(COL_DIM)-1:0]  A,
    output logic [TILE_W-1:0]           tile_idx,
    output logic                        busy,
    output logic                        done
`ifdef INTRA_NET_SCHED_PERF_EN
    ,
    output logic [31:0]                 perf_cycles
`endif
);
    localparam int DW = $clog2(COL_DIM);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_e;

    state_e                state_q, state_d;
    logic                  start_q, start_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] o_base_q, o_base_d;
    logic [ADDR_WIDTH-1:0] a_base_q, a_base_d;
    logic [DW-1:0]         a_q, a_d;
    logic [TILE_W-1:0]     tile_q, tile_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] rows_q, rows_d;
    logic [TILE_W-1:0]     tiles_q, tiles_d;
    logic [ADDR_WIDTH-1:0] o_stride_q, o_stride_d;
    logic [ADDR_WIDTH-1:0] a_stride_q, a_stride_d;

    logic          accept;
    logic          degenerate;
    logic          last_tile;
    logic [DW-1:0] delay_eff;
    logic [CW-1:0] first_load;
    logic [CW-1:0] reload;

    assign accept     = cfg.cfg_valid && (state_q == IDLE);
    assign degenerate = (cfg.cfg_tiles == '0) || (cfg.cfg_rows == '0);
    assign last_tile  = (tile_q == tiles_q - TILE_W'(1));
    // The address generator needs A >= 1, so a zero delay is clamped up.
    assign delay_eff  = (cfg.cfg_delay == '0) ? DW'(1) : cfg.cfg_delay;
    assign first_load = {1'b0, cfg.cfg_rows} + CW'(delay_eff) - CW'(1);
    assign reload     = {1'b0, rows_q} + CW'(a_q) - CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            o_base_q   <= '0;
            a_base_q   <= '0;
            a_q        <= '0;
            tile_q     <= '0;
            cnt_q      <= '0;
            rows_q     <= '0;
            tiles_q    <= '0;
            o_stride_q <= '0;
            a_stride_q <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            done_q     <= done_d;
            o_base_q   <= o_base_d;
            a_base_q   <= a_base_d;
            a_q        <= a_d;
            tile_q     <= tile_d;
            cnt_q      <= cnt_d;
            rows_q     <= rows_d;
            tiles_q    <= tiles_d;
            o_stride_q <= o_stride_d;
            a_stride_q <= a_stride_d;
        end
    end

    // abort outranks both the counter terminal and the GAP decision.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = degenerate ? DONE : RUN;
            RUN: begin
                if (abort)               state_d = IDLE;
                else if (cnt_q == '0)    state_d = GAP;
            end
            GAP: begin
                if (abort)               state_d = IDLE;
                else if (last_tile)      state_d = DONE;
                else                     state_d = RUN;
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_d    = start_q;
        o_base_d   = o_base_q;
        a_base_d   = a_base_q;
        a_d        = a_q;
        tile_d     = tile_q;
        cnt_d      = cnt_q;
        rows_d     = rows_q;
        tiles_d    = tiles_q;
        o_stride_d = o_stride_q;
        a_stride_d = a_stride_q;
        done_d     = (state_d == DONE);
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rows_d     = cfg.cfg_rows;
                    tiles_d    = cfg.cfg_tiles;
                    o_stride_d = cfg.cfg_o_stride;
                    a_stride_d = cfg.cfg_a_stride;
                    o_base_d   = cfg.cfg_o_base;
                    a_base_d   = cfg.cfg_a_base;
                    a_d        = delay_eff;
                    tile_d     = '0;
                    cnt_d      = first_load;
                    start_d    = !degenerate;
                end
            end
            RUN: begin
                if (abort || cnt_q == '0) start_d = 1'b0;
                else                      cnt_d   = cnt_q - CW'(1);
            end
            GAP: begin
                if (abort) begin
                    start_d = 1'b0;
                end else if (!last_tile) begin
                    o_base_d = o_base_q + o_stride_q;
                    a_base_d = a_base_q + a_stride_q;
                    tile_d   = tile_q + TILE_W'(1);
                    cnt_d    = reload;
                    start_d  = 1'b1;
                end
            end
            DONE: start_d = 1'b0;
        endcase
    end

`ifdef INTRA_NET_SCHED_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (accept)                         perf_d = '0;
        else if (start_q && perf_q != '1)   perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

    assign cfg.cfg_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign start_signal  = start_q;
    assign done          = done_q;
    assign O_base_addr   = o_base_q;
    assign A_base_addr   = a_base_q;
    assign A             = a_q;
    assign tile_idx      = tile_q;
endmodule
